// File: rtl/lane_rr_sched.sv
// Round-robin packet scheduler: muxes NREQ requesters onto one registered output lane, 1-cycle latency.
// Backpressure: req_ready[grant] follows (!out_valid || out_ready); a grant is held for a whole packet or MAXB beats.
module lane_rr_sched #(
  parameter int NREQ = 4,
  parameter int MAXB = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NREQ-1:0]                 req_valid,
  input  logic [NREQ-1:0]                 req_last,
  input  logic [NREQ-1:0][0:4][0:4]       req_data,
  output logic [NREQ-1:0]                 req_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [0:4][0:4]                 out_data,
  output logic [$clog2(NREQ)-1:0]         out_src,
  output logic                            out_last
);

  localparam int SW = $clog2(NREQ);
  localparam int CW = $clog2(MAXB + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state;
  logic [SW-1:0]   grant;
  logic [SW-1:0]   last_grant;
  logic [SW-1:0]   next_grant;
  logic [SW-1:0]   cand;
  logic [CW-1:0]   beat_cnt;
  logic            accept;
  logic            release_now;

  // Walk downward so the requester closest after last_grant wins.
  always_comb begin
    next_grant = last_grant;
    cand       = last_grant;
    for (int i = NREQ; i >= 1; i--) begin
      cand = SW'((int'(last_grant) + i) % NREQ);
      if (req_valid[cand]) next_grant = cand;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == XFER) req_ready[grant] = !out_valid || out_ready;
  end

  assign accept      = (state == XFER) && req_valid[grant] && req_ready[grant];
  assign release_now = accept && (req_last[grant] || (beat_cnt == CW'(MAXB - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SW'(NREQ - 1);
      beat_cnt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      out_last   <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= req_data[grant];
        out_src   <= grant;
        out_last  <= release_now;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant    <= next_grant;
            beat_cnt <= '0;
            state    <= XFER;
          end
        end
        XFER: begin
          // A missing beat just stalls here; only a last or MAXB-th beat releases.
          if (accept) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (release_now) begin
              last_grant <= grant;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_rr_sched.sv
// Bench for lane_rr_sched: preloaded per-requester beat queues against a packet-level round-robin model.
module tb_lane_rr_sched;
  localparam int NREQ = 4;
  localparam int MAXB = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_last;
  logic [NREQ-1:0][0:4][0:4] req_data;
  logic [NREQ-1:0]           req_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [0:4][0:4]           out_data;
  logic [1:0]                out_src;
  logic                      out_last;

  int total = 0;
  int bad   = 0;
  int m_last;
  int pops;

  logic [25:0] srcq [NREQ][$];   // {data, last}
  logic [27:0] expq [$];         // {src, data, last}

  lane_rr_sched #(.NREQ(NREQ), .MAXB(MAXB)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_pkt(input int r, input int len);
    for (int b = 0; b < len; b++) srcq[r].push_back({25'($urandom), (b == len - 1)});
  endtask

  // Packet-level arbitration: next non-empty requester after the last one,
  // transfer until its last beat or MAXB beats, then arbitrate again.
  task automatic model();
    logic [25:0] mq [NREQ][$];
    logic [25:0] b;
    int g, n;
    bit lst;
    for (int i = 0; i < NREQ; i++) mq[i] = srcq[i];
    while (1) begin
      g = -1;
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && mq[(m_last + k) % NREQ].size() > 0) g = (m_last + k) % NREQ;
      if (g < 0) break;
      n = 0;
      do begin
        b = mq[g].pop_front();
        n++;
        lst = b[0] || (n == MAXB);
        expq.push_back({2'(g), b[25:1], lst});
      end while (!lst);
      m_last = g;
    end
  endtask

  task automatic drive_inputs();
    logic [25:0] h;
    for (int i = 0; i < NREQ; i++) begin
      if (srcq[i].size() > 0) begin
        h            = srcq[i][0];
        req_valid[i] = 1'b1;
        req_data[i]  = h[25:1];
        req_last[i]  = h[0];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = 25'($urandom);
        req_last[i]  = 1'($urandom);
      end
    end
  endtask

  // mode 0: out_ready=1, mode 1: random out_ready, mode 2: 5-cycle stall after first beat
  task automatic run(input int mode, input int budget);
    int cyc = 0;
    int stall = 0;
    bit seen = 0;
    bit held = 0;
    logic [27:0] prev = '0;
    logic [27:0] e;
    model();
    while (expq.size() > 0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (held) chk("hold", {out_valid, out_src, out_data, out_last}, {1'b1, prev});
      drive_inputs();
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (!seen && out_valid) begin
            seen  = 1;
            stall = 5;
          end
          out_ready = (stall == 0);
          if (stall > 0) stall--;
        end
      endcase
      #1;
      if (out_valid && !out_ready) chk("rdy_stall", 32'(req_ready), 32'd0);
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) void'(srcq[i].pop_front());
      if (out_valid && out_ready) begin
        e = expq.pop_front();
        chk("beat", {out_src, out_data, out_last}, 32'(e));
      end
      held = out_valid && !out_ready;
      prev = {out_src, out_data, out_last};
    end
    chk("timeout_left", expq.size(), 32'd0);
    expq.delete();
    @(posedge clk); #1;
    req_valid = '0;
    out_ready = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    out_ready = 1'b1;
    m_last    = NREQ - 1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_src", 32'(out_src), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("idle_ready", 32'(req_ready), 32'd0);
      chk("idle_valid", 32'(out_valid), 32'd0);
    end

    // 1-beat packets from everyone: 0,1,2,3,0
    push_pkt(0, 1); push_pkt(1, 1); push_pkt(2, 1); push_pkt(3, 1); push_pkt(0, 1);
    run(0, 200);

    // last grant 1, then req2 3-beat packet beats req1
    push_pkt(1, 1);
    run(0, 100);
    push_pkt(2, 3); push_pkt(1, 1);
    run(0, 200);

    // lone requester 3 wraps around to itself
    push_pkt(3, 1); push_pkt(3, 1);
    run(0, 100);

    // long packet from 0 forced out every MAXB beats, 3 slips in after beat 8
    push_pkt(0, 24); push_pkt(3, 1);
    run(0, 400);

    // output stall right after the first beat
    push_pkt(1, 3); push_pkt(2, 2);
    run(2, 300);

    for (int r = 0; r < 6; r++) begin
      for (int q = 0; q < NREQ; q++)
        if ($urandom_range(0, 1) == 1)
          for (int p = 0; p < $urandom_range(1, 3); p++) push_pkt(q, $urandom_range(1, 12));
      run(1, 3000);
    end

    // reset in the middle of a 4-beat packet from requester 3
    push_pkt(3, 4);
    pops = 0;
    for (int c = 0; c < 50 && pops < 2; c++) begin
      @(posedge clk); #1;
      drive_inputs();
      out_ready = 1'b1;
      #1;
      if (req_valid[3] && req_ready[3]) begin
        void'(srcq[3].pop_front());
        pops++;
      end
    end
    chk("pre_rst_pops", pops, 32'd2);
    @(posedge clk); #1;
    chk("beat2_loaded", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_src", 32'(out_src), 32'd0);
    srcq[3].delete();
    req_valid = '0;
    @(posedge clk); #1;
    rst    = 1'b0;
    m_last = NREQ - 1;
    push_pkt(0, 1); push_pkt(2, 1); push_pkt(3, 2);
    run(0, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_rr_sched.md
LANE_RR_SCHED -- requirements
Module: lane_rr_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the output lane.
REQ-002 Parameter MAXB, default 8: maximum beats per grant before forced release.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  [NREQ-1:0]  per-requester beat valid.
REQ-006 Port req_last  input  [NREQ-1:0]  per-requester last beat of packet.
REQ-007 Port req_data  input  [NREQ-1:0][0:4][0:4]  per-requester 25-bit packed beat.
REQ-008 Port req_ready  output  [NREQ-1:0]  per-requester beat accept.
REQ-009 Port out_valid  output  1  output register holds a beat.
REQ-010 Port out_ready  input  1  downstream accepts the output beat.
REQ-011 Port out_data  output  [0:4][0:4]  registered beat.
REQ-012 Port out_src  output  [$clog2(NREQ)-1:0]  requester index of out_data.
REQ-013 Port out_last  output  1  registered last flag; set on forced release too.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and XFER.
REQ-015 In IDLE with any req_valid set, the block SHALL latch grant = first set requester searching (last_grant+1) mod NREQ upward with wrap, then enter XFER next cycle.
REQ-016 In IDLE with no req_valid set, the block SHALL stay in IDLE and hold last_grant.
REQ-017 In IDLE, all req_ready bits SHALL be 0.
REQ-018 In XFER, only req_ready[grant] SHALL be asserted, with value (!out_valid || out_ready); all others SHALL be 0.
REQ-019 An accepted beat (req_valid[grant] && req_ready[grant]) SHALL load out_data, out_src=grant and out_valid=1 on the next edge; latency is one cycle.
REQ-020 When out_valid && out_ready and no beat is loaded, out_valid SHALL clear; a simultaneous accept and load SHALL keep out_valid=1 with the new beat.
REQ-021 While out_valid && !out_ready, out_data, out_src and out_last SHALL remain stable.
REQ-022 beat_cnt SHALL increment per accepted beat and reset to 0 on entry to XFER.
REQ-023 If the accepted beat has req_last[grant]=1, or beat_cnt equals MAXB-1, the block SHALL set out_last=1, set last_grant=grant, and return to IDLE.
REQ-024 Forced release at MAXB SHALL not drop data; that requester's remaining beats compete again in IDLE.
REQ-025 Deassertion of req_valid[grant] in XFER SHALL stall, not release, the grant.
REQ-026 A requester SHALL never be granted twice in succession while another requester has req_valid set in IDLE.
REQ-027 req_data of non-granted requesters SHALL have no effect on any output.

Reset
REQ-028 On rst=1, independent of clk, the block SHALL set state=IDLE, last_grant=NREQ-1, beat_cnt=0, out_valid=0, out_data=0, out_src=0, out_last=0, req_ready=0.
REQ-029 rst asserted mid-XFER SHALL discard the held beat and the partial packet; the first grant after reset SHALL go to requester 0 if valid.
REQ-030 After rst deassertion, the first grant SHALL occur no earlier than the first rising edge with req_valid set.

Verification
REQ-031 Reset, then req_valid=4'b1111, all req_last=1, out_ready=1 -> grants in order 0,1,2,3,0, one-beat packets; out_src follows that order.
REQ-032 Requester 2 sends a 3-beat packet (last on beat 3), requester 1 valid throughout -> out_src=2 for 3 consecutive beats, then 1.
REQ-033 Requester 0 holds req_valid with req_last=0 for 20 beats, MAXB=8 -> out_last=1 on beats 8 and 16; requester 3 valid gets the grant after beat 8.
REQ-034 out_ready=0 for 5 cycles after the first beat -> out_data stable, req_ready[grant]=0, no beat lost or duplicated.
REQ-035 Assert rst during beat 2 of a 4-beat packet from requester 3 -> out_valid=0 at once; next grant goes to requester 0 when valid.
REQ-036 Only requester 3 valid after last_grant=3 -> wrap search grants 3 again.
